// File: rtl/uart_cmd_responder_if.sv
// Byte stream, UART TX request and register bus signals of the command responder.
interface uart_cmd_responder_if;
    logic       rx_ready;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       tx_req;
    logic       tx_busy;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;
    logic [7:0] err_count;

    // Responder side: consumes received bytes, drives TX requests and the register bus.
    modport slave (
        input  rx_ready, rx_byte, tx_busy, bus_rdata,
        output tx_byte, tx_req, bus_addr, bus_wdata, bus_we, bus_re, err_count
    );

    // Host/environment side: UART receiver, UART transmitter and register slave.
    modport master (
        output rx_ready, rx_byte, tx_busy, bus_rdata,
        input  tx_byte, tx_req, bus_addr, bus_wdata, bus_we, bus_re, err_count
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Decodes 'W' addr data / 'R' addr frames from the UART byte stream onto an
// 8-bit register bus and returns one reply byte per frame. An inter-byte
// timeout and a saturating error counter keep the link self-recovering.
module uart_cmd_responder #(
    parameter int unsigned clock_freq     = 100000000,
    parameter int unsigned timeout_cycles = clock_freq / 100
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_cmd_responder_if.slave  io
);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, WR, RD, RD_CAP, REPLY
    } state_t;

    localparam logic [7:0]  CMD_W        = 8'h57;
    localparam logic [7:0]  CMD_R        = 8'h52;
    localparam logic [7:0]  RSP_K        = 8'h4B;
    localparam logic [7:0]  RSP_Q        = 8'h3F;
    localparam logic [31:0] TIMEOUT_LAST = timeout_cycles - 32'd1;

    state_t      state, state_nxt;
    logic [7:0]  cmd, cmd_nxt;
    logic [7:0]  reply, reply_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [7:0]  addr_nxt, wdata_nxt, txb_nxt, err_nxt;
    logic        we_nxt, re_nxt, req_nxt;
    logic        in_frame, timeout, drop;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A byte arriving in the timeout cycle wins, so timeout requires no rx_ready.
    assign in_frame = (state == GET_ADDR) || (state == GET_DATA);
    assign timeout  = in_frame && !io.rx_ready && (cnt == TIMEOUT_LAST);
    assign drop     = io.rx_ready &&
                      ((state == WR) || (state == RD) || (state == RD_CAP) || (state == REPLY));

    // State and all registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd          <= '0;
            reply        <= '0;
            cnt          <= '0;
            io.tx_byte   <= '0;
            io.tx_req    <= 1'b0;
            io.bus_addr  <= '0;
            io.bus_wdata <= '0;
            io.bus_we    <= 1'b0;
            io.bus_re    <= 1'b0;
            io.err_count <= '0;
        end else begin
            state        <= state_nxt;
            cmd          <= cmd_nxt;
            reply        <= reply_nxt;
            cnt          <= cnt_nxt;
            io.tx_byte   <= txb_nxt;
            io.tx_req    <= req_nxt;
            io.bus_addr  <= addr_nxt;
            io.bus_wdata <= wdata_nxt;
            io.bus_we    <= we_nxt;
            io.bus_re    <= re_nxt;
            io.err_count <= err_nxt;
        end
    end

    // Frame sequencing: byte-driven transitions, fixed bus/reply steps, timeout abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (io.rx_ready)
                    state_nxt = (io.rx_byte == CMD_W || io.rx_byte == CMD_R) ? GET_ADDR : REPLY;
            end
            GET_ADDR: begin
                if (io.rx_ready)   state_nxt = (cmd == CMD_W) ? GET_DATA : RD;
                else if (timeout)  state_nxt = IDLE;
            end
            GET_DATA: begin
                if (io.rx_ready)   state_nxt = WR;
                else if (timeout)  state_nxt = IDLE;
            end
            WR:      state_nxt = REPLY;
            RD:      state_nxt = RD_CAP;
            RD_CAP:  state_nxt = REPLY;
            REPLY:   if (!io.tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, latches and the inter-byte counter.
    always_comb begin
        cmd_nxt   = cmd;
        reply_nxt = reply;
        cnt_nxt   = '0;
        addr_nxt  = io.bus_addr;
        wdata_nxt = io.bus_wdata;
        txb_nxt   = io.tx_byte;
        we_nxt    = 1'b0;
        re_nxt    = 1'b0;
        req_nxt   = 1'b0;
        err_nxt   = io.err_count;
        case (state)
            IDLE: begin
                if (io.rx_ready) begin
                    if (io.rx_byte == CMD_W || io.rx_byte == CMD_R) cmd_nxt = io.rx_byte;
                    else                                            reply_nxt = RSP_Q;
                end
            end
            GET_ADDR: begin
                if (io.rx_ready) begin
                    addr_nxt = io.rx_byte;
                    re_nxt   = (cmd != CMD_W);
                end else if (timeout) begin
                    err_nxt = sat_inc(io.err_count);
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            GET_DATA: begin
                if (io.rx_ready) begin
                    wdata_nxt = io.rx_byte;
                    we_nxt    = 1'b1;
                end else if (timeout) begin
                    err_nxt = sat_inc(io.err_count);
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            WR:     reply_nxt = RSP_K;
            RD_CAP: reply_nxt = io.bus_rdata;
            REPLY: begin
                if (!io.tx_busy) begin
                    req_nxt = 1'b1;
                    txb_nxt = reply;
                end
            end
            default: ;
        endcase
        if (drop) err_nxt = sat_inc(io.err_count);
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: expected bus strobes and reply bytes
// (with latency from the last presented byte) are queued as stimulus is sent.
module tb_uart_cmd_responder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy_hold = 1'b0;
    int   busy_cnt = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mem [256];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         lat;
    } exp_t;

    exp_t tx_q[$];
    exp_t wr_q[$];
    exp_t rd_q[$];

    uart_cmd_responder_if ifc();

    uart_cmd_responder #(.clock_freq(100000000), .timeout_cycles(500)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter model: busy for 8 cycles after each accepted request.
    always @(posedge clk) begin
        if (ifc.tx_req)        busy_cnt <= 8;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign ifc.tx_busy = busy_hold || (busy_cnt != 0);

    // Register slave: read data valid the cycle after bus_re.
    always @(posedge clk) begin
        if (ifc.bus_re) ifc.bus_rdata <= mem[ifc.bus_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pop the scoreboard whenever the DUT produces a strobe or request.
    always @(negedge clk) begin
        exp_t e;
        if (ifc.tx_req) begin
            check("tx_vs_busy", ifc.tx_busy, 0);
            if (tx_q.size() == 0) check("tx_extra", 1, 0);
            else begin
                e = tx_q.pop_front();
                check("tx_byte", ifc.tx_byte, e.a);
                check("tx_lat", cyc - last_cyc + 1, e.lat);
            end
        end
        if (ifc.bus_we) begin
            if (wr_q.size() == 0) check("we_extra", 1, 0);
            else begin
                e = wr_q.pop_front();
                check("we_addr", ifc.bus_addr, e.a);
                check("we_data", ifc.bus_wdata, e.b);
                check("we_lat", cyc - last_cyc + 1, e.lat);
            end
        end
        if (ifc.bus_re) begin
            if (rd_q.size() == 0) check("re_extra", 1, 0);
            else begin
                e = rd_q.pop_front();
                check("re_addr", ifc.bus_addr, e.a);
                check("re_lat", cyc - last_cyc + 1, e.lat);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        ifc.rx_ready = 1'b1;
        ifc.rx_byte  = b;
        @(posedge clk);
        #1;
        ifc.rx_ready = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic release_busy();
        busy_hold = 1'b0;
        last_cyc  = cyc;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_tx_byte"}, ifc.tx_byte, 0);
        check({pfx, "_tx_req"}, ifc.tx_req, 0);
        check({pfx, "_bus_addr"}, ifc.bus_addr, 0);
        check({pfx, "_bus_wdata"}, ifc.bus_wdata, 0);
        check({pfx, "_bus_we"}, ifc.bus_we, 0);
        check({pfx, "_bus_re"}, ifc.bus_re, 0);
        check({pfx, "_err"}, ifc.err_count, 0);
    endtask

    initial begin
        ifc.rx_ready  = 1'b0;
        ifc.rx_byte   = 8'h00;
        ifc.bus_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h22] = 8'h3C;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("rst");

        // Write with bytes arriving in the very cycle the timeout would fire.
        wr_q.push_back('{8'h10, 8'hA5, 1});
        tx_q.push_back('{8'h4B, 8'h00, 3});
        send_byte(8'h57);
        idle(498);
        send_byte(8'h10);
        idle(498);
        send_byte(8'hA5);
        idle(20);
        check("wr_err", ifc.err_count, 0);
        check("wr_addr_hold", ifc.bus_addr, 8'h10);

        // Read from a slave returning 0x3C.
        rd_q.push_back('{8'h22, 8'h00, 1});
        tx_q.push_back('{8'h3C, 8'h00, 4});
        send_byte(8'h52);
        send_byte(8'h22);
        idle(20);

        // Unknown command.
        tx_q.push_back('{8'h3F, 8'h00, 2});
        send_byte(8'h00);
        idle(20);

        // Timeout after the address byte, then a normal read.
        send_byte(8'h57);
        send_byte(8'h10);
        idle(499);
        check("to_err_before", ifc.err_count, 0);
        idle(1);
        check("to_err_after", ifc.err_count, 1);
        idle(5);
        rd_q.push_back('{8'h01, 8'h00, 1});
        tx_q.push_back('{8'h5B, 8'h00, 4});
        send_byte(8'h52);
        send_byte(8'h01);
        idle(20);
        check("to_err_keep", ifc.err_count, 1);

        // Reply held off by a busy transmitter, with one dropped byte.
        busy_hold = 1'b1;
        tx_q.push_back('{8'h3F, 8'h00, 2});
        send_byte(8'h00);
        idle(50);
        send_byte(8'h57);
        idle(146);
        check("busy_err", ifc.err_count, 2);
        release_busy();
        idle(20);

        // 300 dropped bytes saturate the error counter.
        busy_hold = 1'b1;
        tx_q.push_back('{8'h3F, 8'h00, 2});
        send_byte(8'h00);
        for (int i = 0; i < 300; i++) send_byte(8'hFF);
        check("err_sat", ifc.err_count, 255);
        release_busy();
        idle(20);
        check("err_sat_hold", ifc.err_count, 255);

        // Reset between address and data of a write, then a full write.
        send_byte(8'h57);
        send_byte(8'h10);
        idle(5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("midrst");
        idle(20);
        wr_q.push_back('{8'h33, 8'h5A, 1});
        tx_q.push_back('{8'h4B, 8'h00, 3});
        send_byte(8'h57);
        send_byte(8'h33);
        send_byte(8'h5A);
        idle(20);

        check("tx_pending", tx_q.size(), 0);
        check("wr_pending", wr_q.size(), 0);
        check("rd_pending", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
